// File: rtl/dcache_pkg.sv
// Shared constants and FSM state type for the direct-mapped data cache.
package dcache_pkg;
  localparam int TAG_W  = 22;
  localparam int IDX_W  = 5;
  localparam int WORD_W = 3;
  localparam int OFF_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    REFILL_DONE
  } state_e;
endpackage

// File: rtl/dcache_sram.sv
// Cache storage: valid/dirty bits (async reset), tag and line arrays (no reset).
// Single write port, asynchronous read.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [LINE_BITS-1:0] line_o,
  input  logic                 we_i,
  input  logic                 wr_dirty_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_line_i
);
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= wr_dirty_i;
    end
  end

  // Tag and data contents are don't-care until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= wr_tag_i;
      data_q[idx_i] <= wr_line_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller with write-allocate.
// Stalls the pipeline through write-back and refill of a missing line.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  state_e state_q, state_d;

  logic [TAG_W-1:0]     addr_tag;
  logic [IDX_W-1:0]     addr_idx;
  logic [WORD_W-1:0]    addr_word;
  logic                 addr_unused;
  logic                 line_valid, line_dirty;
  logic [TAG_W-1:0]     line_tag;
  logic [LINE_BITS-1:0] line_data;
  logic                 req, hit;
  logic                 we;
  logic                 wr_dirty;
  logic [LINE_BITS-1:0] wr_line;

  assign addr_tag    = cpu_addr_i[31:32-TAG_W];
  assign addr_idx    = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign addr_word   = cpu_addr_i[OFF_W-1:2];
  assign addr_unused = ^cpu_addr_i[1:0];

  assign req = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit = req & line_valid & (line_tag == addr_tag);

  dcache_sram #(
    .NUM_LINES(NUM_LINES),
    .LINE_BITS(LINE_BITS)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx_i     (addr_idx),
    .valid_o   (line_valid),
    .dirty_o   (line_dirty),
    .tag_o     (line_tag),
    .line_o    (line_data),
    .we_i      (we),
    .wr_dirty_i(wr_dirty),
    .wr_tag_i  (addr_tag),
    .wr_line_i (wr_line)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    we           = 1'b0;
    wr_dirty     = 1'b0;
    wr_line      = line_data;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          // Read data comes from the line before any same-cycle store lands.
          if (cpu_MemRead_i) cpu_data_o = line_data[{addr_word, 5'b0} +: 32];
          if (cpu_MemWrite_i) begin
            we       = 1'b1;
            wr_dirty = 1'b1;
            wr_line[{addr_word, 5'b0} +: 32] = cpu_data_i;
          end
        end else if (req) begin
          cpu_stall_o = 1'b1;
          state_d     = (line_valid && line_dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {line_tag, addr_idx, {OFF_W{1'b0}}};
        mem_data_o   = line_data;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {addr_tag, addr_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          we      = 1'b1;
          wr_line = mem_data_i;
          state_d = REFILL_DONE;
        end
      end
      REFILL_DONE: begin
        cpu_stall_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: transaction-level cache/memory model
// checked every cycle, plus hand-computed expectations for key scenarios.
module tb_dcache_controller;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o, mem_addr_o;
  logic         cpu_MemRead_i, cpu_MemWrite_i, cpu_stall_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_MemRead_i (cpu_MemRead_i),
    .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o    (cpu_data_o),
    .cpu_stall_o   (cpu_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache contents as the rules say they must be, and the backing memory.
  logic         mvalid [32];
  logic         mdirty [32];
  logic [21:0]  mtag   [32];
  logic [255:0] mline  [32];
  logic [255:0] bmem   [logic [31:0]];

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    if (bmem.exists(a)) return bmem[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {8'hA5, a[23:0]} + 32'(w);
    return l;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin
      mvalid[k] = 1'b0;
      mdirty[k] = 1'b0;
    end
  endtask

  // Memory responder: ack on the lat-th cycle of each request.
  int           lat = 1;
  bit           mem_hold = 0;
  bit           force_ack = 0;
  int           cnt = 0;
  int           ack_kind = 0;
  logic         ack_prev;
  logic [31:0]  rf_addr_q, last_wb_addr, last_rf_addr;
  logic [255:0] rf_line_q, last_wb_data;
  int           wb_count = 0;

  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (ack_kind == 1) begin
        mvalid[rf_addr_q[9:5]] = 1'b1;
        mdirty[rf_addr_q[9:5]] = 1'b0;
        mtag[rf_addr_q[9:5]]   = rf_addr_q[31:10];
        mline[rf_addr_q[9:5]]  = rf_line_q;
      end
      ack_prev  = mem_ack_i;
      mem_ack_i = 1'b0;
      ack_kind  = 0;
      if (force_ack) begin
        mem_ack_i = 1'b1;
        ack_kind  = 3;
        force_ack = 0;
      end else if (mem_enable_o && !mem_hold && !rst) begin
        if (ack_prev) cnt = 0;
        cnt++;
        if (cnt >= lat) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) begin
            ack_kind           = 2;
            bmem[mem_addr_o]   = mem_data_o;
            last_wb_addr       = mem_addr_o;
            last_wb_data       = mem_data_o;
            wb_count++;
          end else begin
            ack_kind     = 1;
            mem_data_i   = mem_line(mem_addr_o);
            rf_addr_q    = mem_addr_o;
            rf_line_q    = mem_data_i;
            last_rf_addr = mem_addr_o;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Per-cycle compare against the model.
  int          en_cycles = 0;
  int          wr_cycles = 0;
  logic [4:0]  c_idx;
  logic [21:0] c_tag;
  logic [2:0]  c_w;
  logic        c_req, c_hit;
  logic [31:0] c_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        c_idx = cpu_addr_i[9:5];
        c_tag = cpu_addr_i[31:10];
        c_w   = cpu_addr_i[4:2];
        c_req = cpu_MemRead_i | cpu_MemWrite_i;
        c_hit = c_req && mvalid[c_idx] && (mtag[c_idx] == c_tag);
        if (mem_enable_o) en_cycles++;
        if (mem_write_o) wr_cycles++;
        if (c_req && !c_hit) chk("miss_stalls", cpu_stall_o, 1);
        if (!c_req) chk("idle_no_stall", cpu_stall_o, 0);
        if (!cpu_stall_o) begin
          if (c_req) chk("release_is_hit", c_hit, 1);
          c_exp = (cpu_MemRead_i && c_hit) ? mline[c_idx][{c_w, 5'b0} +: 32] : 32'h0;
          chk("cpu_data", cpu_data_o, c_exp);
          chk("no_mem_when_running", mem_enable_o, 0);
        end else begin
          chk("cpu_data_stalled", cpu_data_o, 0);
        end
        if (!mem_enable_o) begin
          chk("mem_addr_idle", mem_addr_o, 0);
          chk("mem_write_idle", mem_write_o, 0);
          chk("mem_data_idle", mem_data_o, 0);
        end else if (mem_write_o) begin
          chk("wb_needs_dirty", mvalid[c_idx] & mdirty[c_idx], 1);
          chk("wb_addr", mem_addr_o, {mtag[c_idx], c_idx, 5'b0});
          chk("wb_data", mem_data_o, mline[c_idx]);
        end else begin
          chk("rf_addr", mem_addr_o, {c_tag, c_idx, 5'b0});
        end
        if (!cpu_stall_o && cpu_MemWrite_i && c_hit) begin
          mline[c_idx][{c_w, 5'b0} +: 32] = cpu_data_i;
          mdirty[c_idx] = 1'b1;
        end
      end
    end
  end

  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, output int stalls, output logic [31:0] rdata);
    bit done = 0;
    cpu_addr_i     = addr;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    cpu_data_i     = wdata;
    stalls = 0;
    rdata  = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!cpu_stall_o) begin
        rdata = cpu_data_o;
        done  = 1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL access_timeout: addr %0h still stalled after 200 cycles, expected release", addr);
    end
    @(posedge clk);
    #1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int          st, w0, e0, r0;
  logic [31:0] rd;
  logic [255:0] l40;

  initial begin
    rst = 1'b1;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 0; cpu_MemWrite_i = 0;
    model_clear();
    for (int w = 0; w < 8; w++) l40[w*32 +: 32] = 32'h1111_1111 * (w + 1);
    bmem[32'h40] = l40;
    @(negedge clk);
    chk("rst_mem_en", mem_enable_o, 0);
    chk("rst_data", cpu_data_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", cpu_stall_o, 0);
    chk("post_rst_mem_en", mem_enable_o, 0);
    @(posedge clk); #1;

    // Cold read miss, 10-cycle memory
    lat = 10;
    access(32'h40, 1, 0, 0, st, rd);
    chk("cold_miss_stall_cycles", st, 12);
    chk("cold_miss_data", rd, 32'h1111_1111);

    // Repeat read hits with no memory traffic
    e0 = en_cycles;
    access(32'h40, 1, 0, 0, st, rd);
    chk("hit_stall_cycles", st, 0);
    chk("hit_data", rd, 32'h1111_1111);
    chk("hit_no_mem", en_cycles, e0);

    // Store hit then conflicting read forces write-back
    access(32'h44, 0, 1, 32'hDEAD_BEEF, st, rd);
    chk("store_hit_stall", st, 0);
    lat = 2;
    w0 = wb_count;
    access(32'h440, 1, 0, 0, st, rd);
    chk("evict_wb_count", wb_count, w0 + 1);
    chk("evict_wb_addr", last_wb_addr, 32'h40);
    chk("evict_wb_word1", last_wb_data[63:32], 32'hDEAD_BEEF);
    chk("evict_rf_addr", last_rf_addr, 32'h440);
    chk("evict_stall_cycles", st, 6);
    chk("evict_data", rd, 32'hA500_0440);

    // Clean miss goes straight to refill
    lat = 3;
    w0 = wb_count; r0 = wr_cycles;
    access(32'h800, 1, 0, 0, st, rd);
    chk("clean_wb_count", wb_count, w0);
    chk("clean_no_write", wr_cycles, r0);
    chk("clean_stall_cycles", st, 5);
    chk("clean_data", rd, 32'hA500_0800);

    // Minimum latency: ack in first cycle of write-back and refill
    lat = 1;
    access(32'h808, 0, 1, 32'hCAFE_F00D, st, rd);
    chk("store2_stall", st, 0);
    access(32'h1004, 1, 0, 0, st, rd);
    chk("lat1_stall_cycles", st, 4);
    chk("lat1_wb_addr", last_wb_addr, 32'h800);
    chk("lat1_wb_word2", last_wb_data[95:64], 32'hCAFE_F00D);
    chk("lat1_data", rd, 32'hA500_1001);

    // Read+write together: old word returned, new word stored, line dirty
    lat = 4;
    access(32'h48, 1, 0, 0, st, rd);
    chk("rw_prefetch_stall", st, 6);
    chk("rw_prefetch_data", rd, 32'h3333_3333);
    access(32'h48, 1, 1, 32'h5, st, rd);
    chk("rw_stall", st, 0);
    chk("rw_old_word", rd, 32'h3333_3333);
    access(32'h48, 1, 0, 0, st, rd);
    chk("rw_new_word", rd, 32'h5);
    w0 = wb_count;
    access(32'h448, 1, 0, 0, st, rd);
    chk("rw_dirty_wb", wb_count, w0 + 1);
    chk("rw_wb_addr", last_wb_addr, 32'h40);
    chk("rw_wb_word2", last_wb_data[95:64], 32'h5);

    // Reset mid-refill, then a stray ack
    mem_hold = 1;
    cpu_addr_i = 32'h2000; cpu_MemRead_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_mem_en", mem_enable_o, 1);
    chk("hold_mem_write", mem_write_o, 0);
    chk("hold_mem_addr", mem_addr_o, 32'h2000);
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    cpu_MemRead_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_en", mem_enable_o, 0);
    chk("rst_mid_stall", cpu_stall_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_hold = 0;
    force_ack = 1;
    @(negedge clk);
    chk("stray_ack_mem_en", mem_enable_o, 0);
    chk("stray_ack_stall", cpu_stall_o, 0);
    @(posedge clk); #1;
    lat = 2;
    w0 = wb_count;
    access(32'h40, 1, 0, 0, st, rd);
    chk("post_rst_miss_stall", st, 4);
    chk("post_rst_no_wb", wb_count, w0);
    chk("post_rst_data", rd, 32'h1111_1111);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
